mcpu_irq_ctrl: RTL
==================

# mcpu_irq_ctrl

Parametrised interrupt, clock-enable and data-input controller for the main Z80-class CPU. It generalises the single vblank interrupt to NSRC maskable edge-triggered sources with fixed priority, supplies an IM2 vector (or IM1 0xFF) during interrupt acknowledge, and generates a timed NMI pulse. It also provides a CPU register port for mask and pending state, the CPU clock enable and the CPU read-data latch. It sits between the CPU core and the board address decoder.

## Interface
- NSRC, 4: number of interrupt sources, 1..8; index 0 has highest priority.
- CEN_DIV, 16: clk_sys cycles per CPU clock enable, 2..256.
- IM2, 1: 1 = drive computed vector on acknowledge; 0 = drive 8'hFF (IM1/RST38).
- VEC_BASE, 8'hE0: vector for source 0.
- VEC_STEP, 2: vector increment per source index; sum wraps modulo 256.
- IO_BASE, 8'h00: low-byte I/O address of the mask register; IO_BASE+1 is pending.
- NMI_CEN, 4: nmi_n low time in cen pulses, 1..255.
- clk_sys  in  1  system clock; only clock.
- reset  in  1  asynchronous, active-high reset.
- cen  out  1  CPU clock enable.
- src_in  in  NSRC  interrupt request levels (bit 0 = vblank).
- nmi_in  in  1  NMI request level.
- cpu_ab  in  8  CPU address low byte.
- cpu_dout  in  8  CPU write data.
- cpu_io, cpu_m1, cpu_wr, cpu_rd  in  1 each  active-high CPU strobes.
- bus_din  in  8  decoded memory/IO read data.
- cpu_di  out  8  data to CPU.
- int_n  out  1  maskable interrupt, active-low.
- nmi_n  out  1  NMI, active-low.
- pending  out  NSRC  pending flags.

## Operation
- Reset values: cen 0, divider 0, cpu_di 8'hFF, int_n 1, nmi_n 1, pending 0, mask all ones, edge registers 0, NMI counter 0.
- Clock enable: divider counts 0..CEN_DIV-1, wraps; cen high for the single cycle with count == CEN_DIV-1.
- Source edge: src_d <= src_in each cycle; src_in[i] & ~src_d[i] sets pending[i]. Set occurs regardless of mask.
- int_n <= ~|(pending & mask), registered.
- Acknowledge = cpu_io & cpu_m1. On its first cycle (rising edge of ack): select lowest index i with pending[i] & mask[i]; clear pending[i]; latch vector = IM2 ? VEC_BASE + i*VEC_STEP : 8'hFF. No candidate (spurious ack): vector 8'hFF, nothing cleared.
- cpu_di priority: ack high -> latched vector; else I/O read (cpu_io & cpu_rd & ~cpu_m1) at IO_BASE -> {0, mask}, at IO_BASE+1 -> {0, pending}; else cpu_rd high -> bus_din captured every cycle; else hold.
- I/O write (cpu_io & cpu_wr & ~cpu_m1), acted on once at rising edge of the write strobe: IO_BASE -> mask <= cpu_dout[NSRC-1:0]; IO_BASE+1 -> pending bits with 1 in cpu_dout cleared (W1C). Other addresses ignored.
- Masked pending bits stay set; unmasking them reasserts int_n.
- Simultaneous set and clear (edge vs ack clear or W1C) on the same bit in one cycle: set wins.
- NMI: rising edge of nmi_in loads counter with NMI_CEN and drives nmi_n 0; counter decrements on each cen; nmi_n returns to 1 on the cycle after the counter reaches 0. A new edge while active reloads the counter.
- Async reset mid-acknowledge or mid-NMI returns everything to reset values immediately; the vector is not presented.

## Timing
- src_in high at cycle N sampling edge -> pending set at N+1 -> int_n low at N+2.
- Ack first sampled at cycle A -> pending cleared and vector on cpu_di at A+1; held while ack stays high.
- int_n returns high at A+2 if no other masked-in source is pending.
- cpu_di follows bus_din with one cycle latency while cpu_rd is high.
- Mask write at cycle W -> mask updated at W+1 -> int_n reflects it at W+2.
- cen period is exactly CEN_DIV cycles, including the first after reset release.

## Test plan
- Reset release, CEN_DIV=16: cen pulses at cycles 15, 31, 47; cpu_di=8'hFF, int_n=1, mask=4'hF.
- Pulse src_in[2] and src_in[0] together, then ack: int_n low 2 cycles later; first ack vector 8'hE0 clears bit 0; second ack vector 8'hE4; int_n high after second ack.
- Write mask 4'b1110 at IO_BASE, pulse src_in[0]: pending=4'b0001, int_n stays 1. Write 4'hF: int_n low 2 cycles later. IO read of IO_BASE+1 returns 8'h01.
- W1C write 8'h01 to IO_BASE+1 in the same cycle as a new src_in[0] edge: pending[0] remains 1. Spurious ack with pending=0: cpu_di=8'hFF.
- nmi_in edge, NMI_CEN=4: nmi_n low for 4 cen periods. A re-edge after 2 periods extends the low time to 6 periods total.
- IM2=0: ack with pending[3] set returns 8'hFF. Assert reset during the ack: int_n=1, pending=0, cpu_di=8'hFF at once.

Source files
------------

// File: rtl/mcpu_irq_ctrl.sv
// Main-CPU interrupt controller: NSRC edge-triggered maskable sources with fixed priority,
// IM2/IM1 vectoring on acknowledge, timed NMI pulse, CPU clock enable and read-data latch.
//
// NMI state | meaning
// ----------+--------------------------------------------------------------
// NMI_IDLE  | nmi_n released; waiting for a rising edge on nmi_in
// NMI_HOLD  | nmi_n low; counter runs down on cen, leave one cycle after 0
module mcpu_irq_ctrl #(
   parameter int         NSRC     = 4,
   parameter int         CEN_DIV  = 16,
   parameter int         IM2      = 1,
   parameter logic [7:0] VEC_BASE = 8'hE0,
   parameter int         VEC_STEP = 2,
   parameter logic [7:0] IO_BASE  = 8'h00,
   parameter int         NMI_CEN  = 4
) (
   input  logic            clk_sys,
   input  logic            reset,
   output logic            cen,
   input  logic [NSRC-1:0] src_in,
   input  logic            nmi_in,
   input  logic [7:0]      cpu_ab,
   input  logic [7:0]      cpu_dout,
   input  logic            cpu_io,
   input  logic            cpu_m1,
   input  logic            cpu_wr,
   input  logic            cpu_rd,
   input  logic [7:0]      bus_din,
   output logic [7:0]      cpu_di,
   output logic            int_n,
   output logic            nmi_n,
   output logic [NSRC-1:0] pending
);

   localparam logic [7:0] DIV_LAST = 8'(CEN_DIV - 1);
   localparam logic [7:0] VSTEP    = 8'(VEC_STEP);
   localparam logic [7:0] NMI_LOAD = 8'(NMI_CEN);
   localparam logic [7:0] IO_PEND  = IO_BASE + 8'd1;

   typedef enum logic {NMI_IDLE, NMI_HOLD} nmi_state_t;

   logic [7:0]      div_cnt;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] src_d;
   logic            ack_d;
   logic            wr_d;
   logic            nmi_d;

   logic            ack;
   logic            io_rd;
   logic            io_wr;
   logic            ack_rise;
   logic            wr_rise;
   logic            nmi_rise;
   logic [NSRC-1:0] src_rise;

   logic [NSRC-1:0] cand;
   logic [NSRC-1:0] ack_clr;
   logic [NSRC-1:0] w1c_clr;
   logic [7:0]      ack_vec;
   logic [7:0]      rd_mask;
   logic [7:0]      rd_pend;

   nmi_state_t      nmi_state;
   nmi_state_t      nmi_next;
   logic [7:0]      nmi_cnt;

   // Data bits above NSRC have no register behind them.
   logic            unused_dout_hi;
   assign unused_dout_hi = ^cpu_dout;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         div_cnt <= '0;
      else if (div_cnt == DIV_LAST)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 8'd1;
   end

   assign cen = (div_cnt == DIV_LAST);

   assign ack      = cpu_io & cpu_m1;
   assign io_rd    = cpu_io & cpu_rd & ~cpu_m1;
   assign io_wr    = cpu_io & cpu_wr & ~cpu_m1;
   assign ack_rise = ack & ~ack_d;
   assign wr_rise  = io_wr & ~wr_d;
   assign nmi_rise = nmi_in & ~nmi_d;
   assign src_rise = src_in & ~src_d;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         src_d <= '0;
         ack_d <= 1'b0;
         wr_d  <= 1'b0;
         nmi_d <= 1'b0;
      end else begin
         src_d <= src_in;
         ack_d <= ack;
         wr_d  <= io_wr;
         nmi_d <= nmi_in;
      end
   end

   // Scan from lowest priority upward so the last hit is the winning (lowest) index.
   always_comb begin
      cand    = pending & mask;
      ack_clr = '0;
      ack_vec = 8'hFF;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (cand[i]) begin
            ack_clr    = '0;
            ack_clr[i] = ack_rise;
            ack_vec    = (IM2 != 0) ? (VEC_BASE + VSTEP * 8'(i)) : 8'hFF;
         end
      end
   end

   always_comb begin
      w1c_clr = '0;
      if (wr_rise && (cpu_ab == IO_PEND))
         w1c_clr = cpu_dout[NSRC-1:0];
   end

   // Clears are applied first so a same-cycle source edge always survives.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mask    <= '1;
         pending <= '0;
      end else begin
         if (wr_rise && (cpu_ab == IO_BASE))
            mask <= cpu_dout[NSRC-1:0];
         pending <= (pending & ~(w1c_clr | ack_clr)) | src_rise;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         int_n <= 1'b1;
      else
         int_n <= ~|(pending & mask);
   end

   always_comb begin
      rd_mask             = '0;
      rd_mask[NSRC-1:0]   = mask;
      rd_pend             = '0;
      rd_pend[NSRC-1:0]   = pending;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         cpu_di <= 8'hFF;
      else if (ack) begin
         if (ack_rise)
            cpu_di <= ack_vec;
      end else if (io_rd && (cpu_ab == IO_BASE))
         cpu_di <= rd_mask;
      else if (io_rd && (cpu_ab == IO_PEND))
         cpu_di <= rd_pend;
      else if (cpu_rd)
         cpu_di <= bus_din;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         nmi_state <= NMI_IDLE;
      else
         nmi_state <= nmi_next;
   end

   always_comb begin
      nmi_next = nmi_state;
      case (nmi_state)
         NMI_IDLE: if (nmi_rise) nmi_next = NMI_HOLD;
         NMI_HOLD: if (!nmi_rise && (nmi_cnt == 8'd0)) nmi_next = NMI_IDLE;
         default:  nmi_next = NMI_IDLE;
      endcase
   end

   always_comb begin
      nmi_n = (nmi_state == NMI_IDLE);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         nmi_cnt <= '0;
      else if (nmi_rise)
         nmi_cnt <= NMI_LOAD;
      else if (cen && (nmi_cnt != 8'd0))
         nmi_cnt <= nmi_cnt - 8'd1;
   end

endmodule
